key_conditioner: RTL

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner_pkg.sv | 15 +
 rtl/key_conditioner_channel.sv | 129 ++++++++++++
 rtl/key_conditioner.sv | 59 +++++
 3 files changed

// File: rtl/key_conditioner_pkg.sv
// Shared constants and the repeat-FSM state encoding for the key conditioner.
package key_conditioner_pkg;

  localparam int CLK_HZ       = 50_000_000;
  localparam int DB_CYC_DEF   = 1_000_000;   // 20 ms debounce window at 50 MHz
  localparam int HOLD_CYC_DEF = 25_000_000;  // 0.5 s from press to first repeat
  localparam int RPT_CYC_DEF  = 5_000_000;   // 10 Hz auto-repeat

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HOLD   = 2'b01,
    REPEAT = 2'b10
  } rpt_state_e;

endpackage

// File: rtl/key_conditioner_channel.sv
// One pushbutton: 2-flop synchronizer, debounce counter and press-and-hold repeat FSM.
// Pulse outputs are all registered, so press/release/rpt rise in the same cycle as level changes.
module key_channel
  import key_conditioner_pkg::*;
#(
  parameter int DB_CYC   = DB_CYC_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int RPT_CYC  = RPT_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_n,          // raw, active-low, asynchronous
  output logic       level,          // debounced state, 1 = pressed
  output logic       press,
  output logic       release_pulse,  // "release" is a reserved word
  output logic       rpt,
  output logic       press_next,     // next-cycle press, lets the top register any_press in step
  output rpt_state_e state
);

  localparam int TM_MAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
  localparam int DB_W   = $clog2(DB_CYC);
  localparam int TM_W   = $clog2(TM_MAX);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYC - 1);
  localparam logic [TM_W-1:0] HOLD_LAST = TM_W'(HOLD_CYC - 1);
  localparam logic [TM_W-1:0] RPT_LAST  = TM_W'(RPT_CYC - 1);

  logic            sync1_q, sync_q;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;
  logic            rel_q, rel_d;
  logic            rpt_q, rpt_d;
  logic [TM_W-1:0] timer_q, timer_d;
  rpt_state_e      state_q, state_d;

  // Debounce: count consecutive disagreeing cycles; toggle stable on the DB_CYC-th one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    if (~sync_q != stable_q) begin
      if (cnt_q == DB_LAST) begin
        stable_d = ~stable_q;
        press_d  = ~stable_q;
        rel_d    = stable_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
  end

  // Repeat FSM next state: a falling level overrides everything, including a due repeat.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rpt_d   = 1'b0;
    if (!stable_d) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_d) begin
            state_d = HOLD;
            timer_d = '0;
            rpt_d   = 1'b1;
          end
        end
        HOLD: begin
          if (timer_q == HOLD_LAST) begin
            state_d = REPEAT;
            timer_d = '0;
            rpt_d   = 1'b1;
          end else begin
            timer_d = timer_q + TM_W'(1);
          end
        end
        REPEAT: begin
          if (timer_q == RPT_LAST) begin
            timer_d = '0;
            rpt_d   = 1'b1;
          end else begin
            timer_d = timer_q + TM_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // All channel state; synchronizer resets to the released (high) input level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      sync_q   <= 1'b1;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      rpt_q    <= 1'b0;
      timer_q  <= '0;
      state_q  <= IDLE;
    end else begin
      sync1_q  <= key_n;
      sync_q   <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      rpt_q    <= rpt_d;
      timer_q  <= timer_d;
      state_q  <= state_d;
    end
  end

  assign level         = stable_q;
  assign press         = press_q;
  assign release_pulse = rel_q;
  assign rpt           = rpt_q;
  assign press_next    = press_d;
  assign state         = state_q;

endmodule

// File: rtl/key_conditioner.sv
// Four independent debounced pushbuttons with press/release pulses and auto-repeat.
// Handshake note: no valid/ready here; every pulse output is a one-cycle strobe, valid only when high.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int DB_CYC   = DB_CYC_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int RPT_CYC  = RPT_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] key_n,
  output logic [3:0] level,
  output logic [3:0] press,
  output logic [3:0] release_pulse,
  output logic [3:0] rpt,
  output logic       any_press,
  output logic [7:0] dbg_state    // repeat-FSM state per key, key i in [2i+1:2i]
);

  logic [3:0] press_next;
  logic       any_press_q, any_press_d;

  for (genvar i = 0; i < 4; i++) begin : g_key
    rpt_state_e st;

    key_channel #(
      .DB_CYC  (DB_CYC),
      .HOLD_CYC(HOLD_CYC),
      .RPT_CYC (RPT_CYC)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .key_n        (key_n[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .rpt          (rpt[i]),
      .press_next   (press_next[i]),
      .state        (st)
    );

    assign dbg_state[2*i +: 2] = st;
  end

  // any_press: registered from the channels' next-cycle press so it lines up with press.
  always_comb begin
    any_press_d = |press_next;
  end

  // any_press register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) any_press_q <= 1'b0;
    else          any_press_q <= any_press_d;
  end

  assign any_press = any_press_q;

endmodule
